// File: rtl/isqrt_pipe.sv
// isqrt_pipe: fully pipelined integer square root, y = floor(sqrt(x)).
// Restoring radix-4 digit-by-digit method; each of the n/2 register stages
// resolves one result bit. New argument accepted every cycle, results return
// in issue order after n/2 cycles. No backpressure.
//
// Ports:
//   clk    rising-edge clock
//   rst    synchronous active-high reset (clears stage valid bits only)
//   x_vld  argument valid
//   x      n-bit unsigned argument
//   y_vld  result valid, one pulse per accepted argument
//   y      n/2-bit unsigned result
module isqrt_pipe #(
  parameter int n = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             x_vld,
  input  logic [n-1:0]     x,
  output logic             y_vld,
  output logic [n/2-1:0]   y
);

  localparam int H = n / 2;

  typedef struct packed {
    logic [n-1:0] xr;  // argument bits not yet consumed, MSB-aligned
    logic [H+1:0] r;   // partial remainder
    logic [H-1:0] q;   // partial root
  } stage_t;

  // One digit step: bring down the next two argument bits and try to
  // subtract 4q+1; the outcome of the trial is the next root bit.
  function automatic stage_t root_step(input stage_t s);
    logic [H+1:0] rr;
    logic [H+1:0] t;
    stage_t       o;
    rr   = {s.r[H-1:0], s.xr[n-1:n-2]};
    t    = {s.q, 2'b01};
    o.xr = s.xr << 2;
    if (rr >= t) begin
      o.r = rr - t;
      o.q = H'({s.q, 1'b1});
    end else begin
      o.r = rr;
      o.q = H'({s.q, 1'b0});
    end
    return o;
  endfunction

  stage_t       st_q [H];
  stage_t       st_d [H];
  stage_t       s0;
  logic [H-1:0] vld_q;
  logic [H-1:0] vld_d;

  always_comb begin
    s0.xr   = x;
    s0.r    = '0;
    s0.q    = '0;
    st_d[0] = root_step(s0);
    for (int unsigned i = 1; i < H; i++) begin
      st_d[i] = root_step(st_q[i-1]);
    end
  end

  always_comb begin
    vld_d    = '0;
    vld_d[0] = x_vld;
    for (int unsigned i = 1; i < H; i++) begin
      vld_d[i] = vld_q[i-1];
    end
  end

  // Data registers load unconditionally and are never reset; only the
  // valid chain is cleared, which is enough to discard in-flight work.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < H; i++) begin
      st_q[i] <= st_d[i];
    end
    if (rst) begin
      vld_q <= '0;
    end else begin
      vld_q <= vld_d;
    end
  end

  assign y     = st_q[H-1].q;
  assign y_vld = vld_q[H-1];

  // Remainder never exceeds 2q, so its top two bits and the final stage's
  // remainder/argument registers carry no information downstream.
  logic unused_bits;
  always_comb begin
    unused_bits = (^st_q[H-1].xr) ^ (^st_q[H-1].r);
    for (int unsigned i = 0; i + 1 < H; i++) begin
      unused_bits = unused_bits ^ (^st_q[i].r[H+1:H]);
    end
  end

endmodule
